// File: rtl/decode_div_60s_21ns_40_seq_pkg.sv
// rtl/decode_div_60s_21ns_40_seq_pkg.sv - shared types and constants for the decode-path divider
package decode_div_pkg;

    localparam int DIN0_W = 60;
    localparam int DIN1_W = 21;
    localparam int DOUT_W = 40;
    localparam int CNT_W  = $clog2(DIN0_W + 1);

    // Signed quotient saturation bounds, 2^39-1 and -2^39
    localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/decode_div_60s_21ns_40_seq_if.sv
// rtl/decode_div_60s_21ns_40_seq_if.sv - operand/result handshake bundle for the divider
interface decode_div_60s_21ns_40_seq_if
    import decode_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] quot;
    logic [din1_WIDTH:0]   rem;
    logic                  ovf;
    logic                  dz;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dz
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dz
    );
endinterface

// File: rtl/decode_div_60s_21ns_40_seq_step.sv
// rtl/decode_div_60s_21ns_40_seq_step.sv - one combinational restoring-division step
module decode_div_step #(
    parameter int DW = 21
) (
    input  logic [DW:0]   pr,
    input  logic [DW-1:0] divisor,
    input  logic          din,
    output logic [DW:0]   pr_next,
    output logic          q
);
    logic [DW+1:0] trial;
    logic [DW+1:0] dvs_ext;

    assign trial   = {pr, din};
    assign dvs_ext = {2'b00, divisor};
    assign q       = (trial >= dvs_ext);
    // The kept remainder is always below the divisor, so DW+1 bits suffice
    assign pr_next = q ? (DW+1)'(trial - dvs_ext) : (DW+1)'(trial);
endmodule

// File: rtl/decode_div_60s_21ns_40_seq.sv
// rtl/decode_div_60s_21ns_40_seq.sv - sequential 60s / 21ns divider, one restoring step per enabled cycle
module decode_div_60s_21ns_40_seq
    import decode_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    decode_div_60s_21ns_40_seq_if.slave bus
);
    localparam int RW = din1_WIDTH + 1;
    localparam logic [din0_WIDTH-1:0] NEG_LIM = din0_WIDTH'(1) << (dout_WIDTH - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    // Dividend bits leave at the top while quotient bits enter at the bottom
    logic [din0_WIDTH-1:0] acc;
    logic [RW-1:0]         pr;
    logic [din1_WIDTH-1:0] dvs;
    logic                  sign;
    logic                  dz_flag;

    logic [RW-1:0]         pr_nxt;
    logic                  q_bit;
    logic [dout_WIDTH-1:0] q_lo, q_s;
    logic [RW-1:0]         rem_s;
    logic                  too_big;

    logic [dout_WIDTH-1:0] quot_r;
    logic [RW-1:0]         rem_r;
    logic                  ovf_r, dz_r;

    decode_div_step #(.DW(din1_WIDTH)) u_step (
        .pr      (pr),
        .divisor (dvs),
        .din     (acc[din0_WIDTH-1]),
        .pr_next (pr_nxt),
        .q       (q_bit)
    );

    assign q_lo    = acc[dout_WIDTH-1:0];
    assign q_s     = sign ? -q_lo : q_lo;
    assign rem_s   = sign ? -pr : pr;
    // Negative side reaches one further than positive side
    assign too_big = sign ? (acc > NEG_LIM) : (acc >= NEG_LIM);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_nxt = CALC;
            CALC: if (cnt == CNT_W'(din0_WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            pr      <= '0;
            dvs     <= '0;
            sign    <= 1'b0;
            dz_flag <= 1'b0;
            quot_r  <= '0;
            rem_r   <= '0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    acc     <= bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
                    dvs     <= bus.din1;
                    sign    <= bus.din0[din0_WIDTH-1];
                    dz_flag <= (bus.din1 == '0);
                    pr      <= '0;
                    cnt     <= '0;
                end
                CALC: begin
                    pr  <= pr_nxt;
                    acc <= {acc[din0_WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    dz_r <= dz_flag;
                    if (dz_flag) begin
                        quot_r <= sign ? QMIN : QMAX;
                        rem_r  <= '0;
                        ovf_r  <= 1'b0;
                    end else if (too_big) begin
                        quot_r <= sign ? QMIN : QMAX;
                        rem_r  <= rem_s;
                        ovf_r  <= 1'b1;
                    end else begin
                        quot_r <= q_s;
                        rem_r  <= rem_s;
                        ovf_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quot      = quot_r;
    assign bus.rem       = rem_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;
endmodule

// File: tb/tb_decode_div_60s_21ns_40_seq.sv
// tb/tb_decode_div_60s_21ns_40_seq.sv - directed scoreboard bench for the sequential divider
module tb_decode_div_60s_21ns_40_seq;

    typedef struct {
        logic [39:0] q;
        logic [21:0] r;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [39:0] last_q;
    logic [21:0] last_r;

    decode_div_60s_21ns_40_seq_if #(.din0_WIDTH(60), .din1_WIDTH(21), .dout_WIDTH(40)) bus ();

    decode_div_60s_21ns_40_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic signed [59:0] a, input logic [20:0] b);
        exp_t   e;
        longint sa, sb_l, q, r;
        longint qmax, qmin;
        qmax = (64'sd1 <<< 39) - 1;
        qmin = -(64'sd1 <<< 39);
        sa   = longint'(a);
        sb_l = longint'({43'd0, b});
        if (b == 21'd0) begin
            q = (sa < 0) ? qmin : qmax;
            e.q = q[39:0]; e.r = '0; e.ovf = 1'b0; e.dz = 1'b1;
        end else begin
            q = sa / sb_l;
            r = sa % sb_l;
            e.ovf = 1'b0;
            if (q > qmax) begin q = qmax; e.ovf = 1'b1; end
            if (q < qmin) begin q = qmin; e.ovf = 1'b1; end
            e.q = q[39:0]; e.r = r[21:0]; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Latency counts edges from first presentation of in_valid to the edge raising out_valid
    task automatic do_div(input logic signed [59:0] a, input logic [20:0] b, input bit toggle,
                          input int exp_lat, input bit consume, input string tag);
        int   n;
        bit   got, acc_now;
        exp_t e;
        bus.din0 = a; bus.din1 = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        n = 0; got = 0;
        while (!got && n < 400) begin
            ce = toggle ? (n % 2 == 1) : 1'b1;
            acc_now = ce && bus.in_ready && bus.in_valid;
            tick();
            n++;
            if (acc_now) begin
                bus.in_valid = 1'b0;
                sb.push_back(model(a, b));
            end
            if (bus.out_valid) got = 1;
        end
        ce = 1'b1;
        check({tag, "_seen"}, 64'(got), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (got && consume && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_quot"}, 64'(bus.quot), 64'(e.q));
            check({tag, "_rem"}, 64'(bus.rem), 64'(e.r));
            check({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
            check({tag, "_dz"}, 64'(bus.dz), 64'(e.dz));
            last_q = bus.quot;
            last_r = bus.rem;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        logic [39:0] neg142;
        logic [21:0] neg6;
        reset = 1'b1; ce = 1'b1;
        bus.in_valid = 1'b0; bus.din0 = '0; bus.din1 = '0; bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_quot", 64'(bus.quot), 64'd0);
        check("rst_rem", 64'(bus.rem), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_dz", 64'(bus.dz), 64'd0);

        do_div(-60'sd1000, 21'd7, 1'b0, 62, 1'b1, "m1000_7");
        neg142 = -40'sd142;
        neg6   = -22'sd6;
        check("m1000_7_qconst", 64'(last_q), 64'(neg142));
        check("m1000_7_rconst", 64'(last_r), 64'(neg6));

        do_div(60'sh7FF_FFFF_FFFF_FFFF, 21'd1, 1'b0, 62, 1'b1, "maxpos_1");
        do_div(60'sh800_0000_0000_0000, 21'd1, 1'b0, 62, 1'b1, "minneg_1");
        do_div(-60'sd5, 21'd0, 1'b0, 62, 1'b1, "m5_0");
        do_div(60'sd5, 21'd0, 1'b0, 62, 1'b1, "p5_0");
        do_div(60'sd123456789, 21'd1048575, 1'b0, 62, 1'b1, "big_ce1");
        do_div(60'sd123456789, 21'd1048575, 1'b1, 124, 1'b1, "big_cetog");
        check("cetog_qconst", 64'(last_q), 64'd117);

        do_div(60'sd77777, 21'd13, 1'b0, 62, 1'b0, "hold");
        bus.din0 = -60'sd31415; bus.din1 = 21'd271; bus.in_valid = 1'b1;
        e = sb[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_quot", 64'(bus.quot), 64'(e.q));
            check("hold_rem", 64'(bus.rem), 64'(e.r));
        end
        e = sb.pop_front();
        check("hold_ovf", 64'(bus.ovf), 64'(e.ovf));
        check("hold_dz", 64'(bus.dz), 64'(e.dz));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_consumed", 64'(bus.out_valid), 64'd0);
        check("hold_idle", 64'(bus.in_ready), 64'd1);
        do_div(-60'sd31415, 21'd271, 1'b0, 62, 1'b1, "after_hold");

        bus.din0 = 60'sd1000; bus.din1 = 21'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("rc_busy", 64'(bus.in_ready), 64'd0);
        repeat (29) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rc_in_ready", 64'(bus.in_ready), 64'd1);
        check("rc_out_valid", 64'(bus.out_valid), 64'd0);
        check("rc_quot", 64'(bus.quot), 64'd0);
        check("rc_rem", 64'(bus.rem), 64'd0);
        check("rc_ovf", 64'(bus.ovf), 64'd0);
        check("rc_dz", 64'(bus.dz), 64'd0);
        do_div(60'sd100, 21'd3, 1'b0, 62, 1'b1, "p100_3");
        check("p100_3_qconst", 64'(last_q), 64'd33);
        check("p100_3_rconst", 64'(last_r), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
